// File: rtl/coord_entry_handler.sv
// Serial coordinate entry from three debounced active-low buttons; X then Y, submitted by activity.
// Optional range check of submitted values enabled by defining COORD_RANGE_CHECK_EN.
module coord_entry_handler #(
  parameter int COORD_W   = 4,
  parameter int DB_CYCLES = 16,
  parameter int MAX_X     = 9,
  parameter int MAX_Y     = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               logic_0_button,
  input  logic               logic_1_button,
  input  logic               activity_button,
  input  logic               coord_ack,
  output logic [COORD_W-1:0] x_output,
  output logic [COORD_W-1:0] y_output,
  output logic               valid_coordinate,
  output logic               entry_error,
  output logic [1:0]         entry_phase
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int BCW = $clog2(COORD_W + 1);

  typedef enum logic [1:0] {
    ENTER_X  = 2'd0,
    ENTER_Y  = 2'd1,
    WAIT_ACT = 2'd2,
    VALID    = 2'd3
  } phase_t;

  // Button index: 0 = logic_0, 1 = logic_1, 2 = activity
  logic [2:0]     raw;
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     deb;
  logic [2:0]     press;
  logic [DBW-1:0] db_cnt [3];

  assign raw = {activity_button, logic_1_button, logic_0_button};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      press <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        // Any cycle where the synchronised level matches the debounced one restarts the count
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
            press[i]  <= ~sync2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  phase_t             state;
  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;
  logic [BCW-1:0]     bit_cnt;
  logic               valid_reg;
  logic               err_reg;
  logic               bit_press;
  logic               bit_val;
  logic               act_press;
  logic               reject;

  // Simultaneous bit presses cancel each other
  assign bit_press = press[0] ^ press[1];
  assign bit_val   = press[1];
  assign act_press = press[2];

`ifdef COORD_RANGE_CHECK_EN
  localparam logic [COORD_W-1:0] MAX_X_L = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] MAX_Y_L = COORD_W'(MAX_Y);
  assign reject = (x_reg > MAX_X_L) || (y_reg > MAX_Y_L);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ENTER_X;
      x_reg     <= '0;
      y_reg     <= '0;
      bit_cnt   <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state)
        ENTER_X, ENTER_Y: begin
          // In ENTER_Y the X bits already count as entered, so a submission there is always an error
          if (act_press && (state == ENTER_Y || bit_cnt != '0)) begin
            err_reg <= 1'b1;
            x_reg   <= '0;
            y_reg   <= '0;
            bit_cnt <= '0;
            state   <= ENTER_X;
          end else if (bit_press) begin
            if (state == ENTER_X) x_reg <= {bit_val, x_reg[COORD_W-1:1]};
            else                  y_reg <= {bit_val, y_reg[COORD_W-1:1]};
            if (bit_cnt == BCW'(COORD_W - 1)) begin
              bit_cnt <= '0;
              state   <= (state == ENTER_X) ? ENTER_Y : WAIT_ACT;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        WAIT_ACT: begin
          if (act_press) begin
            if (reject) begin
              err_reg <= 1'b1;
              x_reg   <= '0;
              y_reg   <= '0;
              bit_cnt <= '0;
              state   <= ENTER_X;
            end else begin
              valid_reg <= 1'b1;
              state     <= VALID;
            end
          end
        end
        VALID: begin
          if (coord_ack) begin
            valid_reg <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            bit_cnt   <= '0;
            state     <= ENTER_X;
          end
        end
        default: state <= ENTER_X;
      endcase
    end
  end

  assign x_output         = x_reg;
  assign y_output         = y_reg;
  assign valid_coordinate = valid_reg;
  assign entry_error      = err_reg;
  assign entry_phase      = state;

endmodule

// File: tb/tb_coord_entry_handler.sv
// Scoreboard bench for coord_entry_handler: a bit-queue reference model predicts outputs at known cycles.
module tb_coord_entry_handler;
  localparam int W = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       l0 = 1'b1, l1 = 1'b1, act = 1'b1, ack = 1'b0;
  logic [3:0] x, y;
  logic       valid, err;
  logic [1:0] phase;

  coord_entry_handler #(.COORD_W(W), .DB_CYCLES(D), .MAX_X(9), .MAX_Y(9)) dut (
    .clk(clk), .reset(reset),
    .logic_0_button(l0), .logic_1_button(l1), .activity_button(act),
    .coord_ack(ack),
    .x_output(x), .y_output(y), .valid_coordinate(valid),
    .entry_error(err), .entry_phase(phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         id;
    logic [1:0] ph;
    logic [3:0] x;
    logic [3:0] y;
    logic       v;
    logic       e;
  } snap_t;

  snap_t sb[$];
  int checks = 0;
  int errors = 0;
  int snap_id = 0;

  // Reference model: entered bits kept in order per coordinate
  bit xq[$];
  bit yq[$];
  bit mvalid = 1'b0;

  function automatic logic [1:0] mphase();
    if (mvalid)          return 2'd3;
    if (xq.size() < W)   return 2'd0;
    if (yq.size() < W)   return 2'd1;
    return 2'd2;
  endfunction

  // n entered bits occupy the top n positions, first-entered lowest
  function automatic logic [3:0] mval(input bit is_y);
    logic [3:0] v = '0;
    int n = is_y ? yq.size() : xq.size();
    for (int k = 0; k < n; k++) v[W - n + k] = is_y ? yq[k] : xq[k];
    return v;
  endfunction

  function automatic void mclear();
    xq.delete();
    yq.delete();
    mvalid = 1'b0;
  endfunction

  function automatic bit mreject();
`ifdef COORD_RANGE_CHECK_EN
    return (mval(1'b0) > 4'd9) || (mval(1'b1) > 4'd9);
`else
    return 1'b0;
`endif
  endfunction

  // kind: 0 bit0, 1 bit1, 2 activity, 3 both bits together
  task automatic model_press(input int kind, output bit e);
    logic [1:0] ph = mphase();
    e = 1'b0;
    if (kind == 0 || kind == 1) begin
      if (ph == 2'd0)      xq.push_back(kind[0]);
      else if (ph == 2'd1) yq.push_back(kind[0]);
    end else if (kind == 2) begin
      if (ph == 2'd2) begin
        if (mreject()) begin e = 1'b1; mclear(); end
        else mvalid = 1'b1;
      end else if (ph != 2'd3 && (xq.size() + yq.size()) > 0) begin
        e = 1'b1;
        mclear();
      end
    end
  endtask

  task automatic push_snap(input int tag, input bit e);
    snap_t s;
    s.cyc = tag;
    s.id  = snap_id;
    s.ph  = mphase();
    s.x   = mval(1'b0);
    s.y   = mval(1'b1);
    s.v   = mvalid;
    s.e   = e;
    snap_id++;
    sb.push_back(s);
  endtask

  task automatic press_btn(input int kind);
    bit e;
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    case (kind)
      0: l0 = 1'b0;
      1: l1 = 1'b0;
      2: act = 1'b0;
      default: begin l0 = 1'b0; l1 = 1'b0; end
    endcase
    model_press(kind, e);
    push_snap(c0 + D + 3, e);
    push_snap(c0 + D + 4, 1'b0);
    repeat (D + 6) @(posedge clk);
    #1;
    l0 = 1'b1; l1 = 1'b1; act = 1'b1;
    repeat (D + 6) @(posedge clk);
  endtask

  task automatic do_ack();
    int c0;
    @(posedge clk); #1;
    ack = 1'b1;
    c0 = cyc;
    if (mvalid) mclear();
    push_snap(c0 + 1, 1'b0);
    @(posedge clk); #1;
    ack = 1'b0;
    push_snap(c0 + 2, 1'b0);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset(input int hold);
    int c0;
    @(posedge clk); #1;
    reset = 1'b1;
    c0 = cyc;
    mclear();
    push_snap(c0 + 1, 1'b0);
    repeat (hold) @(posedge clk);
    #1;
    reset = 1'b0;
    push_snap(cyc + 1, 1'b0);
    repeat (3) @(posedge clk);
  endtask

  task automatic enter_val(input logic [3:0] v);
    for (int i = 0; i < W; i++) press_btn(v[i] ? 1 : 0);
  endtask

  task automatic bounce_l1();
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      l1 = ~l1;
      repeat (2) @(posedge clk);
      #1;
    end
    l1 = 1'b1;
    push_snap(cyc + D + 5, 1'b0);
    repeat (D + 8) @(posedge clk);
  endtask

  // Monitor: compares every snapshot due this cycle; flags error pulses nobody predicted
  always @(negedge clk) begin
    snap_t s;
    bit had;
    had = 1'b0;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      s = sb.pop_front();
      had = 1'b1;
      checks++;
      if (s.cyc < cyc) begin
        errors++;
        $display("FAIL snap%0d missed: now cycle %0d, required cycle %0d", s.id, cyc, s.cyc);
      end else if ({phase, x, y, valid, err} !== {s.ph, s.x, s.y, s.v, s.e}) begin
        errors++;
        $display("FAIL snap%0d cyc%0d: got ph=%0d x=%b y=%b v=%b e=%b, expected ph=%0d x=%b y=%b v=%b e=%b",
                 s.id, cyc, phase, x, y, valid, err, s.ph, s.x, s.y, s.v, s.e);
      end
    end
    if (!had && err !== 1'b0 && !reset) begin
      checks++;
      errors++;
      $display("FAIL unexpected_error cyc%0d: got entry_error=%b, required 0", cyc, err);
    end
  end

  initial begin
    int k;
    do_reset(2);

    // Normal entry, submit, acknowledge
    enter_val(4'b0001);
    enter_val(4'b0011);
    press_btn(2);
    press_btn(0);
    press_btn(2);
    do_ack();

    // Bounce on logic_1 after one entered bit
    press_btn(1);
    bounce_l1();
    press_btn(2);

    // Early submission with partial Y
    enter_val(4'b0101);
    press_btn(1);
    press_btn(0);
    press_btn(2);

    // Out-of-range X
    enter_val(4'b1100);
    enter_val(4'b0001);
    press_btn(2);
    do_ack();

    // Both bit buttons together
    press_btn(1);
    press_btn(3);
    press_btn(2);

    // Activity with nothing entered, then coord_ack outside VALID
    press_btn(2);
    do_ack();

    // Reset while VALID, then a full entry
    enter_val(4'b1001);
    enter_val(4'b0110);
    press_btn(2);
    do_reset(1);
    enter_val(4'b1111);
    enter_val(4'b0000);
    press_btn(2);
    do_ack();

    // Randomised actions
    for (int n = 0; n < 50; n++) begin
      k = $urandom_range(0, 9);
      if (k <= 5)      press_btn(k % 2);
      else if (k == 6) press_btn(2);
      else if (k == 7) press_btn(3);
      else if (k == 8) do_ack();
      else             press_btn(2);
    end

    for (int t = 0; t < 300 && sb.size() > 0; t++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d snapshots left, required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coord_entry_handler.md
COORD_ENTRY_HANDLER -- requirements
Module: coord_entry_handler

Interface
REQ-001 SHALL have parameter COORD_W, default 4, bit width of each coordinate (2..8).
REQ-002 SHALL have parameter DB_CYCLES, default 16, consecutive stable samples needed to accept a raw button level change (2..65535).
REQ-003 SHALL have parameter MAX_X, default 9, largest legal X value; only used with RANGE_CHECK_EN.
REQ-004 SHALL have parameter MAX_Y, default 9, largest legal Y value; only used with RANGE_CHECK_EN.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port logic_0_button  input  1  raw active-low button, enters bit 0.
REQ-008 SHALL have port logic_1_button  input  1  raw active-low button, enters bit 1.
REQ-009 SHALL have port activity_button  input  1  raw active-low button, submits the coordinate.
REQ-010 SHALL have port coord_ack  input  1  consumer acknowledge, active-high, sampled only in state VALID.
REQ-011 SHALL have port x_output  output  COORD_W  entered X coordinate.
REQ-012 SHALL have port y_output  output  COORD_W  entered Y coordinate.
REQ-013 SHALL have port valid_coordinate  output  1  high while a submitted coordinate is held for the consumer.
REQ-014 SHALL have port entry_error  output  1  one-cycle pulse on a rejected submission.
REQ-015 SHALL have port entry_phase  output  2  current state encoding: 0 ENTER_X, 1 ENTER_Y, 2 WAIT_ACT, 3 VALID.

Function
REQ-016 SHALL pass each raw button through a 2-flop synchroniser, then a per-button debouncer whose debounced level changes only after the synchronised level differs from it for DB_CYCLES consecutive cycles; any bounce restarts that button's count.
REQ-017 SHALL produce a one-cycle press event on each debounced 1->0 transition; release produces no event; press event occurs DB_CYCLES+2 cycles after a clean raw falling edge.
REQ-018 SHALL in ENTER_X/ENTER_Y, on a bit press, shift the active coordinate right by one and insert the bit at the MSB, so the first entered bit ends at the LSB (presses 1,0,0,0 -> 0001).
REQ-019 SHALL count bits per coordinate; after the COORD_W-th bit, ENTER_X -> ENTER_Y and ENTER_Y -> WAIT_ACT on the next edge.
REQ-020 SHALL ignore both bit presses when logic_0 and logic_1 press events occur in the same cycle.
REQ-021 SHALL ignore bit presses in WAIT_ACT and VALID.
REQ-022 SHALL on activity press in WAIT_ACT go to VALID and assert valid_coordinate on the next edge, or, if rejected (REQ-033), pulse entry_error, clear both coordinates and counts, and return to ENTER_X.
REQ-023 SHALL on activity press in ENTER_X or ENTER_Y with at least one bit entered pulse entry_error and restart at ENTER_X with cleared coordinates; with zero bits entered the press is ignored.
REQ-024 SHALL in VALID hold x_output, y_output and valid_coordinate stable until coord_ack is sampled high, then clear coordinates, deassert valid_coordinate and enter ENTER_X on that edge.
REQ-025 SHALL ignore activity presses in VALID; coord_ack outside VALID has no effect.
REQ-026 SHALL expose the partially entered coordinates live on x_output/y_output during entry.

Reset
REQ-027 SHALL on reset clear x_output, y_output, bit counts, valid_coordinate, entry_error to 0 and entry_phase to 0 (ENTER_X), overriding all other activity in that cycle, including mid-entry and VALID.
REQ-028 SHALL on reset set synchroniser flops and debounced levels to 1 (released) and clear debounce counters.
REQ-029 SHALL, for a button held low through reset, emit one press event DB_CYCLES+2 cycles after reset release.

Configuration
REQ-030 SHALL compile the range check only when macro COORD_RANGE_CHECK_EN is defined.
REQ-031 SHALL without COORD_RANGE_CHECK_EN accept every value in WAIT_ACT; entry_error then arises only from REQ-023.
REQ-032 SHALL with COORD_RANGE_CHECK_EN treat MAX_X/MAX_Y as unsigned COORD_W-bit limits.
REQ-033 SHALL with COORD_RANGE_CHECK_EN reject a submission when x_output > MAX_X or y_output > MAX_Y.

Verification (COORD_W=4, DB_CYCLES=4, MAX_X=MAX_Y=9)
REQ-034 SHALL cover: presses 1,0,0,0 then 1,1,0,0 then activity -> x_output=0001, y_output=0011, valid_coordinate=1 from 1 cycle after activity event; coord_ack pulse -> valid 0, phase 0, outputs 0.
REQ-035 SHALL cover: logic_1 raw toggling every 2 cycles for 20 cycles then settling high -> no press event, x_output unchanged.
REQ-036 SHALL cover: X=0101 entered, 2 Y bits, activity -> one entry_error pulse, phase 0, outputs 0.
REQ-037 SHALL cover (macro defined): X=1100 (12), Y=0001, activity -> entry_error pulse, valid 0; same with macro undefined -> valid 1, x_output=1100.
REQ-038 SHALL cover: logic_0 and logic_1 pressed in the same cycle -> bit count and x_output unchanged.
REQ-039 SHALL cover: reset asserted in VALID -> next edge valid 0, outputs 0, phase 0; later full entry works normally.
